// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//   Boot-time program loader placed in front of the CPU core. It parses a
//   framed byte stream (SYNC, COUNT, 3*N payload bytes, CSUM). It packs each
//   group of three payload bytes into a 19-bit instruction word and writes
//   the words to instruction memory from address 0. The CPU is held in reset
//   until the frame checksum has been verified and RST_HOLD further cycles
//   have passed.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   byte-stream valid
//   in_data    in   byte-stream data [7:0]
//   in_ready   out  loader can accept a byte (low during WRITE and in reset)
//   imem_we    out  instruction-memory write strobe, one cycle per word
//   imem_addr  out  write address [7:0]
//   imem_wdata out  instruction word {opcode[2:0], op1[7:0], op2[7:0]}
//   cpu_rst    out  CPU core reset; high while loading or after an error
//   done       out  successful load, cleared by the next frame start
//   err        out  framing/checksum error, cleared by the next frame start
// ---------------------------------------------------------------------------
module prog_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned RST_HOLD  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [18:0] imem_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_COUNT = 4'd1,
    S_B0    = 4'd2,
    S_B1    = 4'd3,
    S_B2    = 4'd4,
    S_WRITE = 4'd5,
    S_CSUM  = 4'd6,
    S_DONE  = 4'd7,
    S_ERR   = 4'd8
  } state_t;

  localparam logic [7:0] HOLD_INIT = 8'(RST_HOLD);

  state_t      state_q, state_d;
  logic [2:0]  opcode_q, opcode_d;
  logic [7:0]  op1_q, op1_d;
  logic [8:0]  n_q, n_d;          // words in frame, 1..256
  logic [8:0]  word_cnt_q, word_cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  hold_q, hold_d;    // cycles left before cpu_rst release
  logic        imem_we_q, imem_we_d;
  logic [7:0]  imem_addr_q, imem_addr_d;
  logic [18:0] imem_wdata_q, imem_wdata_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        accept_s;
  logic        is_sync_s;

  // The write strobe is masked by rst so a WRITE cycle coincident with reset
  // never reaches memory; in_ready is likewise forced low during reset.
  assign in_ready   = (state_q != S_WRITE) && !rst;
  assign imem_we    = imem_we_q && !rst;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign err        = err_q;

  assign accept_s  = in_valid && in_ready;
  assign is_sync_s = (in_data == SYNC_BYTE);

  // Next-state and output logic of the frame parser
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    op1_d        = op1_q;
    n_d          = n_q;
    word_cnt_d   = word_cnt_q;
    csum_d       = csum_q;
    hold_d       = hold_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_rst_d    = cpu_rst_q;
    done_d       = done_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (accept_s && is_sync_s) begin
          // Frame start: restart from address 0 with the CPU held in reset.
          state_d     = S_COUNT;
          csum_d      = 8'h00;
          word_cnt_d  = 9'd0;
          imem_addr_d = 8'h00;
          cpu_rst_d   = 1'b1;
          done_d      = 1'b0;
          err_d       = 1'b0;
          hold_d      = 8'h00;
        end else if (state_q == S_DONE && hold_q != 8'h00) begin
          hold_d = hold_q - 8'h01;
          if (hold_q == 8'h01) begin
            cpu_rst_d = 1'b0;
          end else begin
            cpu_rst_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_COUNT: begin
        if (accept_s) begin
          // A COUNT of zero encodes a full 256-word image.
          n_d     = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
          state_d = S_B0;
        end else begin
          state_d = S_COUNT;
        end
      end
      S_B0: begin
        if (accept_s) begin
          if (in_data[7:3] != 5'd0) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            opcode_d = in_data[2:0];
            csum_d   = csum_q ^ in_data;
            state_d  = S_B1;
          end
        end else begin
          state_d = S_B0;
        end
      end
      S_B1: begin
        if (accept_s) begin
          op1_d   = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = S_B2;
        end else begin
          state_d = S_B1;
        end
      end
      S_B2: begin
        if (accept_s) begin
          // The op2 byte goes straight into the word register.
          csum_d       = csum_q ^ in_data;
          imem_wdata_d = {opcode_q, op1_q, in_data};
          imem_we_d    = 1'b1;
          state_d      = S_WRITE;
        end else begin
          state_d = S_B2;
        end
      end
      S_WRITE: begin
        // 8-bit address wraps after word 256 without producing another write.
        imem_addr_d = imem_addr_q + 8'h01;
        word_cnt_d  = word_cnt_q + 9'd1;
        if ((word_cnt_q + 9'd1) == n_q) begin
          state_d = S_CSUM;
        end else begin
          state_d = S_B0;
        end
      end
      S_CSUM: begin
        if (accept_s) begin
          if (in_data == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = HOLD_INIT;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end else begin
          state_d = S_CSUM;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cpu_rst_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      opcode_q     <= 3'd0;
      op1_q        <= 8'h00;
      n_q          <= 9'd0;
      word_cnt_q   <= 9'd0;
      csum_q       <= 8'h00;
      hold_q       <= 8'h00;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= 8'h00;
      imem_wdata_q <= 19'd0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      op1_q        <= op1_d;
      n_q          <= n_d;
      word_cnt_q   <= word_cnt_d;
      csum_q       <= csum_d;
      hold_q       <= hold_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//   Table-driven frames plus hand-written sequences for the full 256-word
//   image, mid-frame reset, reset coincident with WRITE and valid gaps.
// ---------------------------------------------------------------------------
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [18:0] imem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;

  prog_loader #(.SYNC_BYTE(8'hA5), .RST_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [18:0] mem [256];
  int          wr_cnt   = 0;
  logic [7:0]  exp_addr = 8'h00;
  int          cyc      = 0;
  int          t_done   = 0;
  int          t_rel    = 0;

  typedef struct {
    logic [95:0] b;        // first byte in bits [95:88]
    int          len;
    logic        exp_done;
    logic        exp_err;
    int          exp_wr;
    logic [18:0] exp_w0;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout: in_ready stayed %0b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model, write-address/ready checking and done/cpu_rst edge capture
  initial begin
    logic done_p, rst_p;
    done_p = 1'b0;
    rst_p  = 1'b1;
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        checks++;
        if (imem_addr !== exp_addr || in_ready !== 1'b0) begin
          failures++;
          $display("FAIL write_addr: addr=%0h ready=%0b, required addr=%0h ready=0",
                   imem_addr, in_ready, exp_addr);
        end
        mem[imem_addr] = imem_wdata;
        wr_cnt++;
        exp_addr++;
      end else if (rst === 1'b0 && in_ready !== 1'b1) begin
        checks++;
        failures++;
        $display("FAIL ready_outside_write: in_ready=%0b, required 1", in_ready);
      end
      if (done === 1'b1 && !done_p) t_done = cyc;
      if (cpu_rst === 1'b0 && rst_p) t_rel = cyc;
      done_p = (done === 1'b1);
      rst_p  = (cpu_rst !== 1'b0);
    end
  end

  initial begin
    logic [7:0] cs;
    int         bad;

    // Each byte is fed through send_byte so the frames double as data tables.
    vecs[0] = '{{8'hA5, 8'h01, 8'h01, 8'h10, 8'h20, 8'h31, 48'h0}, 6, 1'b1, 1'b0, 1, 19'h11020};
    vecs[1] = '{{8'hA5, 8'h01, 8'h01, 8'h10, 8'h20, 8'h30, 48'h0}, 6, 1'b0, 1'b1, 1, 19'h11020};
    vecs[2] = '{{8'hA5, 8'h01, 8'h01, 8'h10, 8'h20, 8'h31, 48'h0}, 6, 1'b1, 1'b0, 1, 19'h11020};
    vecs[3] = '{{8'hA5, 8'h01, 8'h08, 8'h10, 8'h20, 8'h28, 48'h0}, 6, 1'b0, 1'b1, 0, 19'h0};
    vecs[4] = '{{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h01, 8'h07, 8'hFF, 8'hFF, 8'h07, 24'h0},
                9, 1'b1, 1'b0, 1, 19'h7FFFF};
    vecs[5] = '{{8'hA5, 8'h03, 8'h00, 8'h05, 8'h06, 8'h01, 8'h07, 8'h08, 8'h05, 8'h00, 8'h00, 8'h08},
                12, 1'b1, 1'b0, 3, 19'h00506};
    vecs[6] = '{{8'hA5, 8'h01, 8'h02, 8'hA5, 8'hA5, 8'h02, 48'h0}, 6, 1'b1, 1'b0, 1, 19'h2A5A5};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 19'd0;

    // Reset state
    idle(3);
    @(negedge clk);
    check("rst_we",      {31'd0, imem_we},    32'd0);
    check("rst_addr",    {24'd0, imem_addr},  32'd0);
    check("rst_wdata",   {13'd0, imem_wdata}, 32'd0);
    check("rst_done",    {31'd0, done},       32'd0);
    check("rst_err",     {31'd0, err},        32'd0);
    check("rst_cpu_rst", {31'd0, cpu_rst},    32'd1);
    check("rst_ready",   {31'd0, in_ready},   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Table-driven frames
    for (int v = 0; v < NV; v++) begin
      wr_cnt   = 0;
      exp_addr = 8'h00;
      for (int k = 0; k < vecs[v].len; k++) begin
        send_byte(vecs[v].b[95 - 8*k -: 8], 0);
      end
      idle(8);
      check($sformatf("v%0d_done", v), {31'd0, done}, {31'd0, vecs[v].exp_done});
      check($sformatf("v%0d_err", v),  {31'd0, err},  {31'd0, vecs[v].exp_err});
      check($sformatf("v%0d_writes", v), wr_cnt, vecs[v].exp_wr);
      check($sformatf("v%0d_cpu_rst", v), {31'd0, cpu_rst}, {31'd0, !vecs[v].exp_done});
      if (vecs[v].exp_wr > 0) begin
        check($sformatf("v%0d_word0", v), {13'd0, mem[0]}, {13'd0, vecs[v].exp_w0});
      end
      if (vecs[v].exp_done) begin
        check($sformatf("v%0d_release_delay", v), t_rel - t_done, 32'd4);
      end
    end
    check("three_word_w1", {13'd0, mem[1]}, {13'd0, 19'h10708});
    check("three_word_w2", {13'd0, mem[2]}, {13'd0, 19'h50000});

    // Full 256-word image (COUNT = 0)
    wr_cnt   = 0;
    exp_addr = 8'h00;
    cs       = 8'h00;
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b0, b1, b2;
      b0 = 8'(i % 8);
      b1 = 8'(i);
      b2 = ~8'(i);
      cs = cs ^ b0 ^ b1 ^ b2;
      send_byte(b0, 0);
      send_byte(b1, 0);
      send_byte(b2, 0);
    end
    send_byte(cs, 0);
    idle(8);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = 8'(i);
      if (mem[i] !== {3'(i % 8), a, ~a}) bad++;
    end
    check("full_writes",     wr_cnt, 32'd256);
    check("full_contents",   bad,    32'd0);
    check("full_done",       {31'd0, done}, 32'd1);
    check("full_addr_wrap",  {24'd0, imem_addr}, 32'd0);

    // Reset after the second word of a four-word frame
    wr_cnt   = 0;
    exp_addr = 8'h00;
    send_byte(8'hA5, 0);
    send_byte(8'h04, 0);
    send_byte(8'h01, 0); send_byte(8'h11, 0); send_byte(8'h12, 0);
    send_byte(8'h02, 0); send_byte(8'h21, 0); send_byte(8'h22, 0);
    idle(3);
    check("midrst_writes_before", wr_cnt, 32'd2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_cpu_rst", {31'd0, cpu_rst},   32'd1);
    check("midrst_addr",    {24'd0, imem_addr}, 32'd0);
    check("midrst_done",    {31'd0, done},      32'd0);
    check("midrst_ready",   {31'd0, in_ready},  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_byte(8'h03, 0); send_byte(8'h31, 0); send_byte(8'h32, 0);
    send_byte(8'h04, 0); send_byte(8'h41, 0); send_byte(8'h42, 0);
    send_byte(8'h00, 0);
    idle(6);
    check("midrst_writes_after", wr_cnt, 32'd2);
    check("midrst_idle_done",    {31'd0, done},    32'd0);
    check("midrst_idle_err",     {31'd0, err},     32'd0);
    check("midrst_idle_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("midrst_kept_word1",   {13'd0, mem[1]},  {13'd0, 19'h22122});

    // Reset coincident with the WRITE cycle
    wr_cnt   = 0;
    exp_addr = 8'h00;
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    rst = 1'b1;
    @(negedge clk);
    check("wrst_we", {31'd0, imem_we}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    check("wrst_writes", wr_cnt, 32'd0);

    // Three-word frame with random valid gaps
    wr_cnt   = 0;
    exp_addr = 8'h00;
    for (int i = 0; i < 3; i++) mem[i] = 19'd0;
    for (int k = 0; k < vecs[5].len; k++) begin
      send_byte(vecs[5].b[95 - 8*k -: 8], int'($urandom_range(0, 5)));
    end
    idle(8);
    check("gap_w0",   {13'd0, mem[0]}, {13'd0, 19'h00506});
    check("gap_w1",   {13'd0, mem[1]}, {13'd0, 19'h10708});
    check("gap_w2",   {13'd0, mem[2]}, {13'd0, 19'h50000});
    check("gap_done", {31'd0, done},   32'd1);
    check("gap_writes", wr_cnt, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
